quad_input_filter: RTL and testbench



---
 rtl/quad_input_filter.sv | 176 +++++++++++++++++
 tb/tb_quad_input_filter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_input_filter.sv
// Quadrature pin conditioner: synchronises and debounces the two raw encoder pins,
// then drives clean a/b levels, one-cycle edge strobes and a sticky violation flag.
//
// Per-channel debounce FSM (channel 0 = A, channel 1 = B):
//   state       | meaning
//   STABLE_LOW  | committed level 0, sample agrees
//   PEND_HIGH   | level 0, counting consecutive 1 samples
//   STABLE_HIGH | committed level 1, sample agrees
//   PEND_LOW    | level 1, counting consecutive 0 samples
module quad_input_filter #(
    parameter int SYNC_STAGES  = 2,
    parameter int PRESCALE     = 16,
    parameter int STABLE_TICKS = 4,
    parameter int PS_WIDTH     = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic err_clear,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic err
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    localparam logic [PS_WIDTH-1:0]  PS_LAST  = PS_WIDTH'(PRESCALE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic [PS_WIDTH-1:0]    ps_q, ps_d;
    logic                   tick;

    state_t                 state_q [2];
    state_t                 state_d [2];
    logic [CNT_WIDTH-1:0]   cnt_q   [2];
    logic [CNT_WIDTH-1:0]   cnt_d   [2];
    logic [1:0]             lvl_q, lvl_d;
    logic [1:0]             rise_q, rise_d;
    logic [1:0]             fall_q, fall_d;
    logic [1:0]             samp;
    logic [1:0]             commit;
    logic                   err_q, err_d;

    // Only the last flop of each chain is allowed to reach the FSMs.
    assign samp = {sync_b_q[SYNC_STAGES-1], sync_a_q[SYNC_STAGES-1]};

    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], a_raw};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], b_raw};
    end

    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + 1'b1;
    end

    always_comb begin
        lvl_d  = lvl_q;
        rise_d = 2'b00;
        fall_d = 2'b00;
        commit = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (tick) begin
                case (state_q[i])
                    STABLE_LOW: begin
                        if (samp[i]) begin
                            state_d[i] = PEND_HIGH;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                    PEND_HIGH: begin
                        if (!samp[i]) begin
                            state_d[i] = STABLE_LOW;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = STABLE_HIGH;
                            cnt_d[i]   = '0;
                            lvl_d[i]   = 1'b1;
                            rise_d[i]  = 1'b1;
                            commit[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!samp[i]) begin
                            state_d[i] = PEND_LOW;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                    PEND_LOW: begin
                        if (samp[i]) begin
                            state_d[i] = STABLE_HIGH;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = STABLE_LOW;
                            cnt_d[i]   = '0;
                            lvl_d[i]   = 1'b0;
                            fall_d[i]  = 1'b1;
                            commit[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = STABLE_LOW;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // A fresh violation outranks a clear arriving in the same cycle.
    always_comb begin
        err_d = err_q;
        if (commit == 2'b11) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            ps_q     <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= STABLE_LOW;
                cnt_q[i]   <= '0;
            end
            lvl_q  <= 2'b00;
            rise_q <= 2'b00;
            fall_q <= 2'b00;
            err_q  <= 1'b0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            ps_q     <= ps_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            err_q  <= err_d;
        end
    end

    assign a      = lvl_q[0];
    assign b      = lvl_q[1];
    assign a_rise = rise_q[0];
    assign a_fall = fall_q[0];
    assign b_rise = rise_q[1];
    assign b_fall = fall_q[1];
    assign err    = err_q;

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter: a PRESCALE=1 instance for latency,
// glitch, reset and violation sequences, and a PRESCALE=4 instance for tick alignment.
module tb_quad_input_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic a_raw, b_raw, err_clear;
    logic a, b, a_rise, a_fall, b_rise, b_fall, err;

    logic a4_raw, b4_raw, err_clear4;
    logic a4, b4, a4_rise, a4_fall, b4_rise, b4_fall, err4;

    quad_input_filter #(
        .SYNC_STAGES(2), .PRESCALE(1), .STABLE_TICKS(4), .PS_WIDTH(8), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw), .err_clear(err_clear),
        .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall),
        .err(err)
    );

    quad_input_filter #(
        .SYNC_STAGES(2), .PRESCALE(4), .STABLE_TICKS(4), .PS_WIDTH(8), .CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .reset(reset), .a_raw(a4_raw), .b_raw(b4_raw), .err_clear(err_clear4),
        .a(a4), .b(b4), .a_rise(a4_rise), .a_fall(a4_fall), .b_rise(b4_rise), .b_fall(b4_fall),
        .err(err4)
    );

    // Output bundle order: {a, b, a_rise, a_fall, b_rise, b_fall, err}
    logic [6:0] outv;
    assign outv = {a, b, a_rise, a_fall, b_rise, b_fall, err};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic       ar;
        logic       br;
        logic [6:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int n, input logic ar, input logic br, input logic [6:0] exp);
        vec_t v;
        v.ar = ar; v.br = br; v.exp = exp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int k;
        int ra, fa, rb, fb;
        logic pa, pb, na, nb;
        logic [1:0] qseq [4];

        reset = 1'b1;
        a_raw = 0; b_raw = 0; err_clear = 0;
        a4_raw = 0; b4_raw = 0; err_clear4 = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", outv, 7'b0000000);
        check("reset_state4", {a4, b4, a4_rise, a4_fall, b4_rise, b4_fall, err4}, 7'b0000000);

        // PRESCALE=4: commits only on ticks, i.e. edges 4, 8, 12 ... after release
        b4_raw = 1'b1;
        k = 0;
        while (b4 !== 1'b1 && k < 40) begin edge1(); k++; end
        check("b4_rise_seen", b4, 1'b1);
        check("b4_rise_strobe", b4_rise, 1'b1);
        check("b4_rise_on_tick", cyc % 4, 0);
        repeat (5) edge1();
        b4_raw = 1'b0;
        k = 0;
        while (b4 !== 1'b0 && k < 40) begin edge1(); k++; end
        check("b4_fall_latency_ok", (k >= 15 && k <= 21), 1'b1);
        check("b4_fall_strobe", b4_fall, 1'b1);
        check("b4_fall_on_tick", cyc % 4, 0);
        edge1();
        check("b4_fall_one_cycle", {b4, b4_fall, b4_rise}, 3'b000);

        for (int i = 0; i < 20; i++) begin
            edge1();
            check($sformatf("idle%0d", i), outv, 7'b0000000);
        end

        // A step, B 3-cycle glitch, B 4-cycle pulse, A step back
        add(5, 1, 0, 7'b0000000);
        add(1, 1, 0, 7'b1010000);
        add(2, 1, 0, 7'b1000000);
        add(3, 1, 1, 7'b1000000);
        add(5, 1, 0, 7'b1000000);
        add(4, 1, 1, 7'b1000000);
        add(1, 1, 0, 7'b1000000);
        add(1, 1, 0, 7'b1100100);
        add(3, 1, 0, 7'b1100000);
        add(1, 1, 0, 7'b1000010);
        add(1, 1, 0, 7'b1000000);
        add(5, 0, 0, 7'b1000000);
        add(1, 0, 0, 7'b0001000);
        add(1, 0, 0, 7'b0000000);
        foreach (vecs[i]) begin
            a_raw = vecs[i].ar;
            b_raw = vecs[i].br;
            edge1();
            check($sformatf("vec%0d", i), outv, vecs[i].exp);
        end

        // Reset while a strobe is high, then while pending
        a_raw = 1'b1;
        repeat (5) edge1();
        edge1();
        check("pre_reset_rise", outv, 7'b1010000);
        #2 reset = 1'b1;
        #1 check("reset_async", outv, 7'b0000000);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge1();
            check($sformatf("post_reset_pend%0d", i), outv, 7'b0000000);
        end
        edge1();
        check("post_reset_commit", outv, 7'b1010000);
        a_raw = 1'b0;
        repeat (5) edge1();
        edge1();
        check("post_reset_fall", outv, 7'b0001000);

        // Simultaneous commits
        a_raw = 1'b1; b_raw = 1'b1;
        repeat (5) edge1();
        edge1();
        check("double_rise_err", outv, 7'b1110101);
        repeat (3) edge1();
        check("err_sticky", outv, 7'b1100001);
        err_clear = 1'b1;
        edge1();
        err_clear = 1'b0;
        check("err_cleared", outv, 7'b1100000);
        a_raw = 1'b0; b_raw = 1'b0;
        repeat (5) edge1();
        check("double_fall_pending", outv, 7'b1100000);
        err_clear = 1'b1;
        edge1();
        err_clear = 1'b0;
        check("set_beats_clear", outv, 7'b0001011);
        edge1();
        check("err_held", outv, 7'b0000001);
        err_clear = 1'b1;
        edge1();
        err_clear = 1'b0;
        check("err_cleared2", outv, 7'b0000000);

        // Quadrature walk, one channel changes per 10-cycle step
        qseq[0] = 2'b00; qseq[1] = 2'b10; qseq[2] = 2'b11; qseq[3] = 2'b01;
        pa = 1'b0; pb = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            na = qseq[s % 4][1];
            nb = qseq[s % 4][0];
            a_raw = na; b_raw = nb;
            ra = 0; fa = 0; rb = 0; fb = 0;
            for (int c = 0; c < 10; c++) begin
                edge1();
                ra += int'(a_rise); fa += int'(a_fall);
                rb += int'(b_rise); fb += int'(b_fall);
            end
            check($sformatf("quad_strobes%0d", s), {ra[7:0], fa[7:0], rb[7:0], fb[7:0]},
                  {7'd0, (!pa && na), 7'd0, (pa && !na), 7'd0, (!pb && nb), 7'd0, (pb && !nb)});
            check($sformatf("quad_levels%0d", s), {a, b, err}, {na, nb, 1'b0});
            pa = na; pb = nb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
